// File: rtl/fbfly_packet_injector_pkg.sv
// Shared definitions for the flattened-butterfly packet injector.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package fbfly_packet_injector_pkg;

  localparam int NUM_VCS            = 2;
  localparam int VC_IDX_WIDTH       = 1;
  localparam int BUFFER_SIZE        = 8;
  localparam int FLIT_DATA_WIDTH    = 64;
  localparam int ROUTER_ADDR_WIDTH  = 4;
  localparam int MAX_PAYLOAD_LENGTH = 4;
  localparam int LEN_WIDTH          = 3;

  // Ceiling log2, used to size counters from their maximum value.
  function automatic int clogb(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  localparam int CREDIT_WIDTH = clogb(BUFFER_SIZE + 1);

  // Injection channel layout, MSB first: {valid, vc, head, tail, data}.
  localparam int CH_DATA_LSB  = 0;
  localparam int CH_TAIL_BIT  = FLIT_DATA_WIDTH;
  localparam int CH_HEAD_BIT  = FLIT_DATA_WIDTH + 1;
  localparam int CH_VC_LSB    = FLIT_DATA_WIDTH + 2;
  localparam int CH_VALID_BIT = CH_VC_LSB + VC_IDX_WIDTH;
  localparam int CH_WIDTH     = 3 + VC_IDX_WIDTH + FLIT_DATA_WIDTH;

  // Credit return layout, MSB first: {valid, vc}.
  localparam int FC_VC_LSB    = 0;
  localparam int FC_VALID_BIT = VC_IDX_WIDTH;
  localparam int FC_WIDTH     = 1 + VC_IDX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

endpackage

// File: rtl/fbfly_packet_injector_credit_ctr.sv
// Per-VC downstream credit counter; starts full at BUFFER_SIZE.
// Latency: inc/dec visible on count_o the cycle after they are sampled.
// Backpressure: none; a return onto a full counter saturates and sets sticky error_o.
// Ports: clk, reset (async active-low), inc_i (credit returned), dec_i (flit sent),
//        count_o (credits available), error_o (overflow seen since reset).
module injector_credit_ctr
  import fbfly_packet_injector_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [CREDIT_WIDTH-1:0] count_o,
  output logic                    error_o
);

  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic                    error_q, error_d;

  always_comb begin
    count_d = count_q;
    error_d = error_q;
    // A simultaneous send and return cancel out, so only the one-sided cases move the count.
    if (inc_i && !dec_i) begin
      if (count_q == CREDIT_WIDTH'(BUFFER_SIZE)) begin
        error_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= CREDIT_WIDTH'(BUFFER_SIZE);
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign count_o = count_q;
  assign error_o = error_q;

endmodule

// File: rtl/fbfly_packet_injector.sv
// Turns packet requests into head/body/tail flits on one flattened-butterfly injection channel.
// Latency: head flit registered one cycle after request acceptance; packet flits then back-to-back.
// Backpressure: req_ready only while idle; flits stall (valid=0) while the target VC has no credit.
// Ports: clk, reset (async active-low); req_valid/req_ready/req_dest/req_vc/req_length request
//        handshake; channel_out {valid,vc,head,tail,data}; flow_ctrl_in {valid,vc} credit return;
//        busy (packet in progress); error (sticky credit overflow on any VC).
module fbfly_packet_injector
  import fbfly_packet_injector_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ROUTER_ADDR_WIDTH-1:0] req_dest,
  input  logic [VC_IDX_WIDTH-1:0]      req_vc,
  input  logic [LEN_WIDTH-1:0]         req_length,
  output logic [CH_WIDTH-1:0]          channel_out,
  input  logic [FC_WIDTH-1:0]          flow_ctrl_in,
  output logic                         busy,
  output logic                         error
);

  state_e                         state_q;
  logic [ROUTER_ADDR_WIDTH-1:0]   dest_q;
  logic [VC_IDX_WIDTH-1:0]        vc_q;
  logic [LEN_WIDTH-1:0]           len_q;
  logic [LEN_WIDTH-1:0]           idx_q;
  logic [CH_WIDTH-1:0]            channel_q;
  logic                           ready_q;
  logic                           busy_q;

  logic [CREDIT_WIDTH-1:0]        credit [NUM_VCS];
  logic [NUM_VCS-1:0]             vc_err;
  logic [NUM_VCS-1:0]             inc;
  logic [NUM_VCS-1:0]             dec;
  logic                           send;

  function automatic logic [CH_WIDTH-1:0] mk_flit(input logic [VC_IDX_WIDTH-1:0]    vc,
                                                  input logic                       head,
                                                  input logic                       tail,
                                                  input logic [FLIT_DATA_WIDTH-1:0] data);
    return {1'b1, vc, head, tail, data};
  endfunction

  // A flit leaves whenever a packet is in flight and its VC holds at least one credit.
  assign send = ((state_q == ST_HEAD) || (state_q == ST_BODY)) && (credit[vc_q] != '0);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign inc[v] = flow_ctrl_in[FC_VALID_BIT] &&
                    (flow_ctrl_in[FC_VC_LSB +: VC_IDX_WIDTH] == VC_IDX_WIDTH'(v));
    assign dec[v] = send && (vc_q == VC_IDX_WIDTH'(v));

    injector_credit_ctr u_ctr (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (inc[v]),
      .dec_i   (dec[v]),
      .count_o (credit[v]),
      .error_o (vc_err[v])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      vc_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      channel_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      channel_q <= '0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (req_valid && ready_q) begin
            dest_q  <= req_dest;
            vc_q    <= req_vc;
            len_q   <= req_length;
            idx_q   <= '0;
            state_q <= ST_HEAD;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_HEAD: begin
          if (send) begin
            channel_q <= mk_flit(vc_q, 1'b1, (len_q == '0),
                                 FLIT_DATA_WIDTH'({len_q, dest_q}));
            idx_q     <= LEN_WIDTH'(1);
            if (len_q == '0) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (send) begin
            channel_q <= mk_flit(vc_q, 1'b0, (idx_q == len_q), FLIT_DATA_WIDTH'(idx_q));
            idx_q     <= idx_q + 1'b1;
            // Ready rises with the tail so the following cycle is the mandatory idle gap.
            if (idx_q == len_q) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign channel_out = channel_q;
  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign error       = |vc_err;

endmodule

// File: tb/tb_fbfly_packet_injector.sv
module tb_fbfly_packet_injector;
  import fbfly_packet_injector_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         req_valid;
  logic                         req_ready;
  logic [ROUTER_ADDR_WIDTH-1:0] req_dest;
  logic [VC_IDX_WIDTH-1:0]      req_vc;
  logic [LEN_WIDTH-1:0]         req_length;
  logic [CH_WIDTH-1:0]          channel_out;
  logic [FC_WIDTH-1:0]          flow_ctrl_in;
  logic                         busy;
  logic                         error;

  fbfly_packet_injector dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dest     (req_dest),
    .req_vc       (req_vc),
    .req_length   (req_length),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: expected flit stream, credits, sticky error.
  logic [CH_WIDTH-1:0]     exp_q[$];
  logic [VC_IDX_WIDTH-1:0] ret_q[$];
  int                      credit_m[NUM_VCS];
  bit                      err_m = 1'b0;
  bit                      auto_ret = 1'b0;
  int                      n_flits = 0;
  int                      last_flit_cyc = -1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CH_WIDTH-1:0] mk(input logic [VC_IDX_WIDTH-1:0] vc, input bit h,
                                             input bit t, input logic [63:0] d);
    return {1'b1, vc, h, t, d};
  endfunction

  // Monitor: every valid flit is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (reset && channel_out[CH_VALID_BIT]) begin
      n_flits++;
      last_flit_cyc = cyc;
      if (auto_ret) ret_q.push_back(channel_out[CH_VC_LSB +: VC_IDX_WIDTH]);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %0h expected none", channel_out);
      end else begin
        chk("flit", channel_out, exp_q.pop_front());
      end
    end
  end

  // Downstream model: hands back one credit per received flit after a random delay.
  always @(negedge clk) begin
    if (auto_ret) begin
      if (ret_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        logic [VC_IDX_WIDTH-1:0] v;
        v = ret_q.pop_front();
        credit_m[v]++;
        flow_ctrl_in = {1'b1, v};
      end else begin
        flow_ctrl_in = '0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queues the packet's expected flits, then waits for req_ready and issues it.
  task automatic send_req(input logic [3:0] dest, input logic [0:0] vc, input logic [2:0] len,
                          output int acc);
    int t;
    exp_q.push_back(mk(vc, 1'b1, (len == 0), 64'({len, dest})));
    for (int i = 1; i <= int'(len); i++) exp_q.push_back(mk(vc, 1'b0, (i == int'(len)), 64'(i)));
    credit_m[vc] -= int'(len) + 1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: got ready=0 expected ready=1 within 300 cycles");
      acc = -1;
    end else begin
      req_dest   = dest;
      req_vc     = vc;
      req_length = len;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic ret(input logic [0:0] vc);
    @(negedge clk);
    flow_ctrl_in = {1'b1, vc};
    if (credit_m[vc] >= BUFFER_SIZE) err_m = 1'b1;
    else credit_m[vc]++;
    @(negedge clk);
    flow_ctrl_in = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int acc, acc2, m, n0, t;
    reset = 1'b0; req_valid = 1'b0; req_dest = '0; req_vc = '0; req_length = '0;
    flow_ctrl_in = '0;
    for (int v = 0; v < NUM_VCS; v++) credit_m[v] = BUFFER_SIZE;
    wait_cycles(3);
    chk("rst_channel", channel_out, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;

    // Single head-only packet: one-cycle latency, credit consumed (return does not overflow).
    send_req(4'h9, 1'b1, 3'd0, acc);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    wait_cycles(2);
    chk("t1_latency", last_flit_cyc, acc + 1);
    chk("t1_idle", busy, 0);
    ret(1'b1);
    wait_cycles(1);
    chk("t1_credit_was_7", error, err_m);

    // Four-flit packet: consecutive flits, ready low for four cycles.
    n0 = n_flits;
    send_req(4'h5, 1'b0, 3'd3, acc);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("t2_ready", req_ready, (k == 4));
    end
    wait_cycles(2);
    chk("t2_count", n_flits - n0, 4);
    chk("t2_last_cyc", last_flit_cyc, acc + 4);
    repeat (4) ret(1'b0);

    // Exhaust vc0, then a ninth packet stalls until one credit comes back.
    for (int i = 0; i < BUFFER_SIZE; i++) send_req(4'($urandom_range(0, 15)), 1'b0, 3'd0, acc);
    wait_cycles(3);
    n0 = n_flits;
    send_req(4'h3, 1'b0, 3'd0, acc);
    wait_cycles(6);
    chk("t3_stalled", n_flits, n0);
    chk("t3_busy", busy, 1);
    chk("t3_no_valid", channel_out[CH_VALID_BIT], 0);
    @(negedge clk);
    flow_ctrl_in = {1'b1, 1'b0};
    credit_m[0]++;
    @(posedge clk);
    #1;
    m = cyc;
    flow_ctrl_in = '0;
    wait_cycles(3);
    chk("t3_resume_cyc", last_flit_cyc, m + 1);
    chk("t3_resume_cnt", n_flits, n0 + 1);

    // vc0 starved with vc1 waiting behind it: no bypass, vc1 follows vc0's tail.
    send_req(4'h7, 1'b0, 3'd1, acc);
    fork
      send_req(4'h2, 1'b1, 3'd0, acc2);
      begin
        repeat (6) begin
          @(negedge clk);
          chk("t4_blocked", req_ready, 0);
        end
        ret(1'b0);
        ret(1'b0);
      end
    join
    wait_cycles(3);
    chk("t4_vc1_after", last_flit_cyc, acc2 + 1);
    repeat (BUFFER_SIZE) ret(1'b0);
    ret(1'b1);
    wait_cycles(1);
    chk("t4_error", error, err_m);

    // Random traffic with a well-behaved downstream returning credits.
    auto_ret = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send_req(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, MAX_PAYLOAD_LENGTH)), acc);
      wait_cycles($urandom_range(0, 3));
    end
    t = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rand_drain", exp_q.size() + ret_q.size(), 0);
    wait_cycles(2);
    auto_ret = 1'b0;
    flow_ctrl_in = '0;
    wait_cycles(1);
    chk("rand_error", error, err_m);

    // Send and return on vc1 in the same cycle leave its counter full.
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 64'({3'd0, 4'hA})));
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_dest = 4'hA; req_vc = 1'b1; req_length = 3'd0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    flow_ctrl_in = {1'b1, 1'b1};
    @(posedge clk);
    #1;
    flow_ctrl_in = '0;
    wait_cycles(2);
    chk("t6_send_cyc", last_flit_cyc, acc + 1);
    chk("t6_no_overflow", error, err_m);
    ret(1'b1);
    wait_cycles(1);
    chk("t6_overflow", error, err_m);
    wait_cycles(5);
    chk("t6_sticky", error, 1);

    // Reset in the middle of a five-flit packet.
    send_req(4'h6, 1'b0, 3'd4, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t7_valid_low", channel_out[CH_VALID_BIT], 0);
    chk("t7_busy_low", busy, 0);
    chk("t7_error_clr", error, 0);
    exp_q.delete();
    for (int v = 0; v < NUM_VCS; v++) credit_m[v] = BUFFER_SIZE;
    err_m = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    n0 = n_flits;
    wait_cycles(3);
    chk("t7_no_partial", n_flits, n0);
    ret(1'b0);
    wait_cycles(1);
    chk("t7_credit_full", error, err_m);
    send_req(4'hC, 1'b0, 3'd0, acc);
    wait_cycles(3);
    chk("t7_clean_head", last_flit_cyc, acc + 1);

    wait_cycles(3);
    chk("final_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
